// File: rtl/dnc_pkg.sv
// dnc_pkg: shared DNC interface-vector parser state set and field ordering
// Used by the write-interface parser and reusable by the read-interface parser.
package dnc_pkg;
  typedef enum logic [2:0] {IDLE, K, BETA, E, V, GA, GW} dnc_state_e;
  localparam dnc_state_e FIRST_FIELD = K;
  localparam dnc_state_e FIRST_SCALAR = BETA;
  function automatic logic is_vector(dnc_state_e s);
    return s == K || s == E || s == V;
  endfunction
  // Field order K, BETA, E, V, GA, GW; vector fields vanish when W is zero
  function automatic dnc_state_e next_field(dnc_state_e s, logic w_zero);
    return s == K ? BETA : s == BETA ? (w_zero ? GA : E) : s == E ? V :
           s == V ? GA : s == GA ? GW : IDLE;
  endfunction
endpackage

// File: rtl/dnc_interface_field_counter.sv
// dnc_interface_field_counter: element index within a vector field plus last-element flag
// Ports: clk/rst (sync, active-high), clear_i zeroes the index, inc_i advances it,
// len_i is the field length, idx_o the current index, last_o high at index len_i-1.
module dnc_interface_field_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [WIDTH-1:0] len_i,
  output logic [WIDTH-1:0] idx_o,
  output logic             last_o
);
  logic [WIDTH-1:0] idx_q;
  always_ff @(posedge clk)
    if (rst || clear_i) idx_q <= '0;
    else if (inc_i) idx_q <= idx_q + WIDTH'(1);
  assign idx_o = idx_q;
  assign last_o = idx_q == len_i - WIDTH'(1);
endmodule

// File: rtl/dnc_write_interface_vector.sv
// dnc_write_interface_vector: serial parser of a DNC write-head interface vector
// Ports: CLK, RST (sync, active-high); START/SIZE_W_IN begin a parse of length W;
// XI_IN_ENABLE/XI_IN carry the serial words; K/E/V_OUT(_ENABLE) strobe vector
// elements one cycle after acceptance; BETA/GA/GW_OUT hold scalars; READY pulses
// with the GW update. Macro DNC_WRITE_INTERFACE_ERROR_EN adds a sticky ERROR output.
module dnc_write_interface_vector
  import dnc_pkg::*;
#(
  parameter int DATA_SIZE = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  input  logic [DATA_SIZE-1:0] SIZE_W_IN,
  input  logic                 XI_IN_ENABLE,
  input  logic [DATA_SIZE-1:0] XI_IN,
  output logic                 K_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] K_OUT,
  output logic [DATA_SIZE-1:0] BETA_OUT,
  output logic                 E_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] E_OUT,
  output logic                 V_OUT_ENABLE,
  output logic [DATA_SIZE-1:0] V_OUT,
  output logic [DATA_SIZE-1:0] GA_OUT,
  output logic [DATA_SIZE-1:0] GW_OUT
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
  ,
  output logic                 ERROR
`endif
);
  if (CONTROL_SIZE < 1) begin : g_bad_control_size
    $error("CONTROL_SIZE must be positive");
  end
  dnc_state_e state_q, state_d;
  logic [DATA_SIZE-1:0] w_q, w_d, idx_unused;
  logic [DATA_SIZE-1:0] k_q, beta_q, e_q, v_q, ga_q, gw_q;
  logic k_en_q, e_en_q, v_en_q, ready_q;
  logic accept, start_ok, vec_field, last, field_done;
  assign accept = XI_IN_ENABLE && state_q != IDLE;
  assign start_ok = START && state_q == IDLE;
  assign vec_field = is_vector(state_q);
  assign field_done = accept && (!vec_field || last);
  always_comb begin
    w_d = start_ok ? SIZE_W_IN : w_q;
    state_d = start_ok ? (SIZE_W_IN == '0 ? FIRST_SCALAR : FIRST_FIELD) :
              field_done ? next_field(state_q, w_q == '0) : state_q;
  end
  dnc_interface_field_counter #(.WIDTH(DATA_SIZE)) u_cnt (
    .clk    (CLK),
    .rst    (RST),
    .clear_i(start_ok || (accept && vec_field && last)),
    .inc_i  (accept && vec_field && !last),
    .len_i  (w_q),
    .idx_o  (idx_unused),
    .last_o (last)
  );
  always_ff @(posedge CLK)
    if (RST) begin
      state_q <= IDLE;
      w_q <= '0;
      {k_en_q, e_en_q, v_en_q, ready_q} <= '0;
      {k_q, beta_q, e_q, v_q, ga_q, gw_q} <= '0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      k_en_q <= accept && state_q == K;
      e_en_q <= accept && state_q == E;
      v_en_q <= accept && state_q == V;
      ready_q <= accept && state_q == GW;
      if (accept && state_q == K) k_q <= XI_IN;
      if (accept && state_q == BETA) beta_q <= XI_IN;
      if (accept && state_q == E) e_q <= XI_IN;
      if (accept && state_q == V) v_q <= XI_IN;
      if (accept && state_q == GA) ga_q <= XI_IN;
      if (accept && state_q == GW) gw_q <= XI_IN;
    end
  assign READY = ready_q;
  assign K_OUT_ENABLE = k_en_q;
  assign K_OUT = k_q;
  assign BETA_OUT = beta_q;
  assign E_OUT_ENABLE = e_en_q;
  assign E_OUT = e_q;
  assign V_OUT_ENABLE = v_en_q;
  assign V_OUT = v_q;
  assign GA_OUT = ga_q;
  assign GW_OUT = gw_q;
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
  logic err_q;
  always_ff @(posedge CLK)
    if (RST) err_q <= 1'b0;
    else if ((start_ok && SIZE_W_IN == '0) || (XI_IN_ENABLE && state_q == IDLE)) err_q <= 1'b1;
    else if (start_ok) err_q <= 1'b0;
  assign ERROR = err_q;
`endif
endmodule

// File: tb/tb_dnc_write_interface_vector.sv
// tb_dnc_write_interface_vector: scoreboard bench for the write-interface parser
module tb_dnc_write_interface_vector;
  logic CLK = 0, RST = 1, START = 0, XI_IN_ENABLE = 0;
  logic [63:0] SIZE_W_IN = 0, XI_IN = 0;
  logic READY, K_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE;
  logic [63:0] K_OUT, BETA_OUT, E_OUT, V_OUT, GA_OUT, GW_OUT;
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
  logic ERROR;
`endif
  dnc_write_interface_vector dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .SIZE_W_IN(SIZE_W_IN),
    .XI_IN_ENABLE(XI_IN_ENABLE), .XI_IN(XI_IN),
    .K_OUT_ENABLE(K_OUT_ENABLE), .K_OUT(K_OUT), .BETA_OUT(BETA_OUT),
    .E_OUT_ENABLE(E_OUT_ENABLE), .E_OUT(E_OUT), .V_OUT_ENABLE(V_OUT_ENABLE), .V_OUT(V_OUT),
    .GA_OUT(GA_OUT), .GW_OUT(GW_OUT)
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
    , .ERROR(ERROR)
`endif
  );
  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;
  // kind: 0 K, 1 E, 2 V, 3 GW/READY, 4 BETA, 5 GA
  typedef struct {int kind; logic [63:0] d; logic [63:0] b; logic [63:0] g; int c;} item_t;
  item_t q[$];
  int passed = 0, total = 0;
  logic [63:0] exp_beta = 0, exp_ga = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask
  task automatic check_zero(string name);
    check({name, "_ready"}, 64'(READY), 0);
    check({name, "_enables"}, 64'({K_OUT_ENABLE, E_OUT_ENABLE, V_OUT_ENABLE}), 0);
    check({name, "_k"}, K_OUT, 0);
    check({name, "_beta"}, BETA_OUT, 0);
    check({name, "_e"}, E_OUT, 0);
    check({name, "_v"}, V_OUT, 0);
    check({name, "_ga"}, GA_OUT, 0);
    check({name, "_gw"}, GW_OUT, 0);
  endtask
  task automatic pop_cmp(int kind, logic [63:0] d);
    item_t it;
    if (q.size() == 0) begin
      total++;
      $display("FAIL unexpected_strobe: kind %0d data %0d at cycle %0d, expected none", kind, d, cyc);
      return;
    end
    it = q.pop_front();
    check("strobe_kind", 64'(kind), 64'(it.kind));
    check("strobe_data", d, it.d);
    check("strobe_cycle", 64'(cyc), 64'(it.c));
    if (kind == 3) begin
      check("beta_held", BETA_OUT, it.b);
      check("ga_held", GA_OUT, it.g);
    end
  endtask
  always @(negedge CLK) begin
    if (K_OUT_ENABLE) pop_cmp(0, K_OUT);
    if (E_OUT_ENABLE) pop_cmp(1, E_OUT);
    if (V_OUT_ENABLE) pop_cmp(2, V_OUT);
    if (READY) pop_cmp(3, GW_OUT);
    while (q.size() > 0 && q[0].c < cyc) begin
      total++;
      $display("FAIL missing_strobe: kind %0d data %0d due cycle %0d, got nothing by %0d", q[0].kind, q[0].d, q[0].c, cyc);
      void'(q.pop_front());
    end
  end
  task automatic word(logic [63:0] d, int kind);
    item_t it;
    XI_IN_ENABLE = 1;
    XI_IN = d;
    if (kind == 4) exp_beta = d;
    if (kind == 5) exp_ga = d;
    it.kind = kind; it.d = d; it.b = exp_beta; it.g = exp_ga; it.c = cyc + 1;
    if (kind < 4) q.push_back(it);
    @(posedge CLK); #1;
  endtask
  task automatic start(int w);
    START = 1;
    SIZE_W_IN = 64'(w);
    XI_IN_ENABLE = 0;
    @(posedge CLK); #1;
    START = 0;
  endtask
  task automatic idle(int n);
    XI_IN_ENABLE = 0;
    repeat (n) begin @(posedge CLK); #1; end
  endtask
  function automatic int kind_of(int i, int w);
    return i < w ? 0 : i == w ? 4 : i < 2*w+1 ? 1 : i < 3*w+1 ? 2 : i == 3*w+1 ? 5 : 3;
  endfunction
  task automatic send_vec(int w, int base, int gap_after, int gap, bit mid);
    for (int i = 0; i < 3*w+3; i++) begin
      if (mid && i == 1) begin START = 1; SIZE_W_IN = 7; end
      word(64'(base + i), kind_of(i, w));
      START = 0;
      if (i == gap_after) idle(gap);
    end
    XI_IN_ENABLE = 0;
  endtask
  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check_zero("reset");
    RST = 0;
    start(2);
    send_vec(2, 1, -1, 0, 0);
    start(2);
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
    check("error_clear", 64'(ERROR), 0);
`endif
    send_vec(2, 1, 3, 3, 1);
    start(0);
    send_vec(0, 10, -1, 0, 0);
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
    check("error_w0", 64'(ERROR), 1);
`endif
    idle(2);
    XI_IN_ENABLE = 1;
    XI_IN = 99;
    @(posedge CLK); #1;
    idle(1);
    check("idle_word_ignored_beta", BETA_OUT, 10);
    start(3);
`ifdef DNC_WRITE_INTERFACE_ERROR_EN
    check("error_cleared_by_start", 64'(ERROR), 0);
`endif
    word(1, 0); word(2, 0); word(3, 0); word(4, 4); word(5, 1);
    XI_IN_ENABLE = 0;
    RST = 1;
    @(posedge CLK); #1;
    check_zero("mid_reset");
    RST = 0;
    exp_beta = 0;
    exp_ga = 0;
    start(1);
    send_vec(1, 20, -1, 0, 0);
    idle(4);
    check("beta_final", BETA_OUT, 21);
    check("scoreboard_empty", 64'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
